// File: rtl/ej32_fetch_if.sv
// eJ32 fetch bus: memory read port plus the control bus toward the execution units.
// master is the fetch unit; slave is the memory/execution side.
`timescale 1ns/1ps
interface ej32_fetch_if #(
   parameter int unsigned ASZ = 17
);
   logic           mem_req_o;
   logic [ASZ-1:0] mem_addr_o;
   logic           mem_ack_i;
   logic [7:0]     mem_data_i;
   logic [7:0]     code_o;
   logic [2:0]     phase_o;
   logic [7:0]     data_o;
   logic           data_v_o;
   logic [ASZ-1:0] p_o;
   logic           exec_o;
   logic           stall_i;
   logic           pop_i;
   logic           adv_i;
   logic           done_i;
   logic [ASZ-1:0] br_p_i;
   logic           br_psel_i;

   modport master (
      output mem_req_o, mem_addr_o, code_o, phase_o, data_o, data_v_o, p_o, exec_o,
      input  mem_ack_i, mem_data_i, stall_i, pop_i, adv_i, done_i, br_p_i, br_psel_i
   );

   modport slave (
      input  mem_req_o, mem_addr_o, code_o, phase_o, data_o, data_v_o, p_o, exec_o,
      output mem_ack_i, mem_data_i, stall_i, pop_i, adv_i, done_i, br_p_i, br_psel_i
   );
endinterface

// File: rtl/ej32_fetch.sv
// eJ32 instruction fetch: byte prefetch FIFO, opcode latch and phase sequencer,
// with branch redirect that flushes prefetched and in-flight bytes.
`timescale 1ns/1ps
module ej32_fetch #(
   parameter int unsigned ASZ    = 17,
   parameter int unsigned FDEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   ej32_fetch_if.master bus
);
   localparam int unsigned AW = $clog2(FDEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] FullCnt = PW'(FDEPTH);

   typedef enum logic [0:0] {StFetchOp, StExec} state_e;

   state_e         state_q, state_d;
   logic [7:0]     code_q, code_d;
   logic [2:0]     phase_q, phase_d;
   logic [ASZ-1:0] p_q, p_d;
   logic [ASZ-1:0] addr_q, addr_d;
   logic           req_q, req_d;
   logic           flush_q, flush_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [7:0]     fifo_q [FDEPTH];

   logic [PW-1:0]  count, count_d;
   logic [7:0]     head;
   logic           empty, redirect, push, op_pop, opnd_pop, data_v;

   assign count    = wr_ptr_q - rd_ptr_q;
   assign empty    = (count == '0);
   assign head     = fifo_q[rd_ptr_q[AW-1:0]];
   assign redirect = bus.br_psel_i && !bus.stall_i;
   // Bytes landing during a flush or a redirect belong to the abandoned stream.
   assign push     = bus.mem_ack_i && !flush_q && !redirect;
   assign data_v   = (state_q == StExec) && !empty;
   assign op_pop   = (state_q == StFetchOp) && !empty && !bus.stall_i && !redirect;
   assign opnd_pop = (state_q == StExec) && bus.pop_i && data_v && !bus.stall_i && !redirect;

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      phase_d  = phase_q;
      p_d      = p_q;
      addr_d   = addr_q;
      req_d    = req_q;
      flush_d  = flush_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         addr_d   = addr_q + ASZ'(1);
      end
      if (op_pop || opnd_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         p_d      = p_q + ASZ'(1);
      end
      if (op_pop) begin
         code_d  = head;
         phase_d = 3'd0;
         state_d = StExec;
      end
      if ((state_q == StExec) && !bus.stall_i && !redirect) begin
         if (bus.done_i) begin
            state_d = StFetchOp;
         end else if (bus.adv_i && (phase_q != 3'd7)) begin
            phase_d = phase_q + 3'd1;
         end
      end
      if (redirect) begin
         p_d      = bus.br_p_i;
         addr_d   = bus.br_p_i;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         state_d  = StFetchOp;
      end

      count_d = wr_ptr_d - rd_ptr_d;
      if (flush_q) begin
         req_d = 1'b0;
         if (bus.mem_ack_i) flush_d = 1'b0;
      end else if (req_q) begin
         if (bus.mem_ack_i) begin
            req_d = 1'b0;
         end else if (redirect) begin
            // Read already issued to the old stream: wait out its ack and drop it.
            req_d   = 1'b0;
            flush_d = 1'b1;
         end
      end else begin
         req_d = (count_d < FullCnt);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StFetchOp;
         code_q   <= 8'h00;
         phase_q  <= 3'd0;
         p_q      <= '0;
         addr_q   <= '0;
         req_q    <= 1'b0;
         flush_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         phase_q  <= phase_d;
         p_q      <= p_d;
         addr_q   <= addr_d;
         req_q    <= req_d;
         flush_q  <= flush_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q[AW-1:0]] <= bus.mem_data_i;
   end

   assign bus.mem_req_o  = req_q;
   assign bus.mem_addr_o = addr_q;
   assign bus.code_o     = code_q;
   assign bus.phase_o    = phase_q;
   assign bus.p_o        = p_q;
   assign bus.exec_o     = (state_q == StExec);
   assign bus.data_o     = head;
   assign bus.data_v_o   = data_v;
endmodule
